// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        FS_REQ     = 2'd0,
        FS_HOLD    = 2'd1,
        FS_DISCARD = 2'd2
    } fetch_state_t;

    typedef enum logic {
        NOERROR        = 1'b0,
        INSTR_MISALIGN = 1'b1
    } fetch_err_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_PEND     = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        fetch_err_t  error;
    } fetch_data_t;

    function automatic logic is_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_pcgen.sv
// Next-PC selection for the fetch controller: hold, pc+4, redirect target
// or the redirect parked while a stale request drained.
module fetch_ctrl_pcgen
    import fetch_ctrl_pkg::*;
(
    input  fetch_state_t state,
    input  logic [63:0]  pc,
    input  logic [63:0]  pend_pc,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    input  logic         data_ok,
    input  logic         ready,
    output logic [63:0]  next_pc
);

    pc_sel_t sel;

    // Choose the PC source from the current state and this cycle's events.
    always_comb begin
        sel = PC_HOLD;
        case (state)
            // A redirect without data_ok keeps pc as the in-flight address;
            // the target is parked in pend_pc instead. A misaligned pc has
            // no request on the bus, so its redirect takes effect at once.
            FS_REQ: begin
                if (redirect_valid && (data_ok || is_misaligned(pc)))
                    sel = PC_REDIRECT;
            end
            FS_HOLD: begin
                if (redirect_valid)
                    sel = PC_REDIRECT;
                else if (ready)
                    sel = PC_INC;
            end
            FS_DISCARD: begin
                if (data_ok)
                    sel = redirect_valid ? PC_REDIRECT : PC_PEND;
            end
            default: sel = PC_HOLD;
        endcase
    end

    // Apply the selected source; pc+4 wraps naturally at 64 bits.
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_INC:      next_pc = pc + 64'd4;
            PC_REDIRECT: next_pc = redirect_pc;
            PC_PEND:     next_pc = pend_pc;
            default:     next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues ibus requests, holds the
// returned instruction for decode and drains stale requests after redirects.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  FS_REQ     | request for pc outstanding (none if pc is misaligned)
//  FS_HOLD    | instruction (or misalign error) held until decode takes it
//  FS_DISCARD | stale request still in flight; pend_pc is the next target
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF,
    output logic        busy
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  pend_pc;
    logic [31:0]  instr_q;
    fetch_err_t   error_q;
    logic [63:0]  next_pc;
    logic         misaligned;
    logic         unused_resp;

    assign misaligned  = is_misaligned(pc);
    // addr_ok and the upper data half carry nothing this stage needs.
    assign unused_resp = ^{iresp.addr_ok, iresp.data[63:32]};

    fetch_ctrl_pcgen u_pcgen (
        .state          (state),
        .pc             (pc),
        .pend_pc        (pend_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .data_ok        (iresp.data_ok),
        .ready          (ready),
        .next_pc        (next_pc)
    );

    // FSM plus pc / pend_pc / instruction holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FS_REQ;
            pc      <= RESET_PC;
            pend_pc <= '0;
            instr_q <= '0;
            error_q <= NOERROR;
        end else begin
            pc <= next_pc;
            case (state)
                FS_REQ: begin
                    if (misaligned) begin
                        if (!redirect_valid) begin
                            state   <= FS_HOLD;
                            instr_q <= '0;
                            error_q <= INSTR_MISALIGN;
                        end
                    end else if (redirect_valid) begin
                        if (!iresp.data_ok) begin
                            pend_pc <= redirect_pc;
                            state   <= FS_DISCARD;
                        end
                    end else if (iresp.data_ok) begin
                        instr_q <= iresp.data[31:0];
                        error_q <= NOERROR;
                        state   <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid || ready)
                        state <= FS_REQ;
                end
                FS_DISCARD: begin
                    if (iresp.data_ok)
                        state <= FS_REQ;
                    else if (redirect_valid)
                        pend_pc <= redirect_pc;
                end
                default: state <= FS_REQ;
            endcase
        end
    end

    // Bus request and decode-facing outputs, all silenced during reset.
    // In DISCARD pc still holds the address of the in-flight request.
    always_comb begin
        ireq.valid  = reset && ((state == FS_REQ && !misaligned) || state == FS_DISCARD);
        ireq.addr   = pc;
        busy        = reset && (state != FS_HOLD);
        dataF.pc    = pc;
        dataF.instr = instr_q;
        dataF.error = error_q;
        dataF.valid = reset && (state == FS_HOLD) && !redirect_valid;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then randomized traffic against
// a flag-based behavioural model checked every cycle.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;
    logic        busy;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .ready          (ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Instruction bus model: one outstanding request, fixed or random latency.
    logic        rst_req;
    bit          b_out;
    int          b_cnt;
    logic [63:0] b_addr;
    int          lat_sel;
    bit          lat_rand;

    task automatic cyc();
        @(posedge clk);
        #1;
        reset          = rst_req;
        redirect_valid = 1'b0;
        #1;
        if (iresp.data_ok) b_out = 1'b0;
        iresp.data_ok = 1'b0;
        iresp.addr_ok = 1'($urandom_range(0, 1));
        if (!reset) begin
            b_out = 1'b0;
        end else begin
            if (!b_out && ireq.valid) begin
                b_out  = 1'b1;
                b_addr = ireq.addr;
                b_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_sel;
            end
            if (b_out) begin
                if (b_cnt == 0) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = {32'hCAFE_F00D, instr_of(b_addr)};
                end else begin
                    b_cnt--;
                end
            end
        end
    endtask

    task automatic redir(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    // Behavioural model: m_pc is the wanted / in-flight address, m_stale marks
    // an in-flight request whose result must be thrown away, m_next is where
    // fetch resumes afterwards, m_held means an instruction awaits decode.
    logic [63:0] m_pc, m_next;
    bit          m_held, m_stale, m_err;

    always @(negedge clk) begin : model
        bit exp_iv, exp_dv, exp_busy, aligned;
        aligned = (m_pc[1:0] == 2'b00);
        if (!reset) begin
            exp_iv = 0; exp_dv = 0; exp_busy = 0;
        end else begin
            exp_iv   = m_stale || (!m_held && aligned);
            exp_busy = !m_held;
            exp_dv   = m_held && !redirect_valid;
        end
        chk("ireq.valid", 64'(ireq.valid), 64'(exp_iv));
        if (exp_iv) chk("ireq.addr", ireq.addr, m_pc);
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("dataF.valid", 64'(dataF.valid), 64'(exp_dv));
        if (exp_dv) begin
            chk("dataF.pc", dataF.pc, m_pc);
            chk("dataF.instr", 64'(dataF.instr), m_err ? 64'd0 : 64'(instr_of(m_pc)));
            chk("dataF.error", 64'(dataF.error), m_err ? 64'd1 : 64'd0);
        end
        if (!reset) begin
            m_pc = RESET_PC_DEFAULT; m_held = 0; m_stale = 0; m_err = 0; m_next = '0;
        end else if (m_held) begin
            if (redirect_valid) begin
                m_pc = redirect_pc; m_held = 0;
            end else if (ready) begin
                m_pc = m_pc + 64'd4; m_held = 0;
            end
        end else if (m_stale) begin
            if (iresp.data_ok) begin
                m_pc    = redirect_valid ? redirect_pc : m_next;
                m_stale = 0;
            end else if (redirect_valid) begin
                m_next = redirect_pc;
            end
        end else if (!aligned) begin
            if (redirect_valid) m_pc = redirect_pc;
            else begin m_held = 1; m_err = 1; end
        end else if (redirect_valid) begin
            if (iresp.data_ok) m_pc = redirect_pc;
            else begin m_stale = 1; m_next = redirect_pc; end
        end else if (iresp.data_ok) begin
            m_held = 1; m_err = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rst_req = 1'b0; ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; iresp = '0; lat_rand = 0; lat_sel = 2; b_out = 0;
        b_cnt = 0; b_addr = '0;

        repeat (3) cyc();
        #1;
        chk("rst ireq.valid", 64'(ireq.valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst dataF.valid", 64'(dataF.valid), 64'd0);

        // 1: first fetch, data_ok two cycles after issue
        rst_req = 1'b1; ready = 1'b1; lat_sel = 2;
        cyc(); #1;
        chk("t1 issue valid", 64'(ireq.valid), 64'd1);
        chk("t1 issue addr", ireq.addr, 64'h8000_0000);
        cyc(); cyc(); #1;
        chk("t1 data_ok cycle dataF.valid", 64'(dataF.valid), 64'd0);
        cyc(); #1;
        chk("t1 dataF.valid", 64'(dataF.valid), 64'd1);
        chk("t1 dataF.pc", dataF.pc, 64'h8000_0000);
        chk("t1 dataF.instr", 64'(dataF.instr), 64'h9357_9BDF);
        chk("t1 dataF.error", 64'(dataF.error), 64'd0);
        lat_sel = 1;
        cyc(); #1;
        chk("t1 next addr", ireq.addr, 64'h8000_0004);
        ready = 1'b0;

        // 2: decode stalls three cycles
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t2 stall valid", 64'(dataF.valid), 64'd1);
            chk("t2 stall pc", dataF.pc, 64'h8000_0004);
            chk("t2 stall instr", 64'(dataF.instr), 64'h9357_9BDB);
            chk("t2 stall ireq.valid", 64'(ireq.valid), 64'd0);
        end
        cyc(); ready = 1'b1; #1;
        chk("t2 accept valid", 64'(dataF.valid), 64'd1);
        lat_sel = 4;
        cyc(); #1;
        chk("t2 next addr", ireq.addr, 64'h8000_0008);

        // 3: redirect one cycle after issue, stale data drained
        cyc(); redir(64'h8000_1000); #1;
        chk("t3 addr held", ireq.addr, 64'h8000_0008);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t3 addr held", ireq.addr, 64'h8000_0008);
            chk("t3 valid held", 64'(ireq.valid), 64'd1);
            chk("t3 no dataF", 64'(dataF.valid), 64'd0);
        end
        cyc(); #1;
        chk("t3 target addr", ireq.addr, 64'h8000_1000);
        chk("t3 no dataF", 64'(dataF.valid), 64'd0);

        // 4: two redirects while discarding; latest wins
        cyc(); redir(64'h100); #1;
        cyc(); redir(64'h200); #1;
        chk("t4 addr held", ireq.addr, 64'h8000_1000);
        cyc(); cyc(); #1;
        chk("t4 addr held", ireq.addr, 64'h8000_1000);
        lat_sel = 1;
        cyc(); #1;
        chk("t4 target addr", ireq.addr, 64'h200);

        // 5a: redirect coincident with data_ok
        cyc(); redir(64'h300); #1;
        chk("t5a no dataF", 64'(dataF.valid), 64'd0);
        cyc(); #1;
        chk("t5a target addr", ireq.addr, 64'h300);
        chk("t5a no dataF", 64'(dataF.valid), 64'd0);
        // 5b: redirect in HOLD with ready=1
        cyc(); cyc(); ready = 1'b1; redir(64'h400); #1;
        chk("t5b forced invalid", 64'(dataF.valid), 64'd0);
        cyc(); #1;
        chk("t5b target addr", ireq.addr, 64'h400);

        // 6: misaligned redirect, then reset mid-discard
        cyc(); cyc(); redir(64'h8000_0002);
        cyc(); #1;
        chk("t6 misalign no req", 64'(ireq.valid), 64'd0);
        cyc(); #1;
        chk("t6 err valid", 64'(dataF.valid), 64'd1);
        chk("t6 err pc", dataF.pc, 64'h8000_0002);
        chk("t6 err instr", 64'(dataF.instr), 64'd0);
        chk("t6 err code", 64'(dataF.error), 64'(INSTR_MISALIGN));
        redir(64'h500); lat_sel = 3;
        cyc(); #1;
        chk("t6 addr 500", ireq.addr, 64'h500);
        cyc(); redir(64'h600);
        rst_req = 1'b0;
        cyc(); #1;
        chk("t6 reset ireq.valid", 64'(ireq.valid), 64'd0);
        chk("t6 reset busy", 64'(busy), 64'd0);
        rst_req = 1'b1;
        cyc(); #1;
        chk("t6 post-reset valid", 64'(ireq.valid), 64'd1);
        chk("t6 post-reset addr", ireq.addr, 64'h8000_0000);

        // Randomized traffic
        lat_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_req = ($urandom_range(0, 199) != 0);
            cyc();
            ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0:       redir(64'h8000_0000 + 64'($urandom_range(1, 3)));
                    1:       redir(64'hFFFF_FFFF_FFFF_FFF8);
                    default: redir(64'h8000_0000 + (64'($urandom_range(0, 1023)) << 2));
                endcase
            end
        end
        cyc();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
